// File: rtl/mips_pkg.sv
// Shared processor package: datapath width, fetch-queue defaults
// and the fetch-queue entry layout.
package mips_pkg;

    localparam int XLEN = 32;

    localparam int FQ_DEPTH = 4;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] INST_BYTES = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fq_entry_t;

    function automatic logic [XLEN-1:0] word_align(
        input logic [XLEN-1:0] addr
    );
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the fetch-queue memory and decode-side signals.
// master is the fetch unit, slave is memory plus decode.
interface fetch_queue_if;
    import mips_pkg::*;

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            inst_valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;

    modport master (
        input  redirect,
        input  redirect_pc,
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        output redirect,
        output redirect_pc,
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, inst} entries with flush and an explicit
// occupancy count that separates full from empty.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  fq_entry_t     wdata,
    input  logic          pop,
    output fq_entry_t     rdata,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fq_entry_t     mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          clear;
    logic          do_pop;
    logic          do_push;

    assign clear   = reset || flush;
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && !clear && ((count != FULL_CNT) || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetch-PC register, one-deep in-flight
// tracking with redirect kill, and a credit check against the FIFO.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int              DEPTH    = FQ_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic            inflight;
    logic [XLEN-1:0] inflight_pc;

    logic [CW-1:0]   count;
    logic [CW-1:0]   occupancy;
    logic            fifo_empty;
    logic            pop;
    logic            push;
    logic            room;
    fq_entry_t       wr_entry;
    fq_entry_t       head;

    assign occupancy = count + CW'(inflight);
    assign inst_valid = !fifo_empty && !reset;
    assign pop        = inst_valid && inst_ready;

    // A slot is free now, or the head leaves in the same edge.
    assign room = (occupancy < FULL_CNT)
               || ((occupancy == FULL_CNT) && pop);

    assign imem_req  = !reset && !redirect && room;
    assign imem_addr = word_align(fetch_pc);

    // A redirect kills the outstanding response.
    assign push          = inflight && !redirect;
    assign wr_entry.pc   = inflight_pc;
    assign wr_entry.inst = imem_rdata;

    assign inst    = head.inst;
    assign inst_pc = head.pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= word_align(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect) begin
            fetch_pc <= word_align(redirect_pc);
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc <= imem_addr;
                fetch_pc    <= imem_addr + INST_BYTES;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop && !redirect),
        .rdata (head),
        .empty (fifo_empty),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus randomized bench for fetch_queue against a
// queue-based behavioural model of the fetch rules.
module tb_fetch_queue;
    import mips_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fetch_queue_if bus ();

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (bus.redirect),
        .redirect_pc (bus.redirect_pc),
        .imem_req    (bus.imem_req),
        .imem_addr   (bus.imem_addr),
        .imem_rdata  (bus.imem_rdata),
        .inst_valid  (bus.inst_valid),
        .inst        (bus.inst),
        .inst_pc     (bus.inst_pc),
        .inst_ready  (bus.inst_ready)
    );

    int ntests = 0;
    int nfail  = 0;

    logic [63:0] q [$];
    logic [31:0] m_pc;
    logic        m_inf;
    logic [31:0] m_inf_pc;

    logic [31:0] req_log [$];
    logic        obs_valid;
    logic [31:0] obs_pc;
    logic [$clog2(DEPTH):0] obs_cnt;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic        e_valid;
        logic        e_pop;
        logic        e_req;
        logic [63:0] head;
        int          occ;
        @(negedge clk);
        e_valid = !reset && (q.size() != 0);
        head    = e_valid ? q[0] : 64'h0;
        e_pop   = e_valid && bus.inst_ready;
        occ     = q.size() + (m_inf ? 1 : 0);
        e_req   = !reset && !bus.redirect
               && (occ < DEPTH || (occ == DEPTH && e_pop));
        chk("imem_req", bus.imem_req, e_req);
        if (e_req) chk("imem_addr", bus.imem_addr, m_pc);
        chk("inst_valid", bus.inst_valid, e_valid);
        if (e_valid) begin
            chk("inst_pc", bus.inst_pc, head[63:32]);
            chk("inst", bus.inst, head[31:0]);
        end
        obs_valid = bus.inst_valid;
        obs_pc    = bus.inst_pc;
        obs_cnt   = dut.u_fifo.count;
        if (bus.imem_req) req_log.push_back(bus.imem_addr);
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_pc  = 32'h0;
            m_inf = 1'b0;
        end else if (bus.redirect) begin
            q.delete();
            m_pc  = {bus.redirect_pc[31:2], 2'b00};
            m_inf = 1'b0;
        end else begin
            if (e_pop) void'(q.pop_front());
            if (m_inf) q.push_back({m_inf_pc, bus.imem_rdata});
            m_inf = e_req;
            if (e_req) begin
                m_inf_pc = m_pc;
                m_pc     = m_pc + 32'd4;
            end
        end
        #1;
        bus.imem_rdata = e_req ? pat(m_inf_pc) : $urandom();
    endtask

    initial begin
        int          fv;
        int          nv;
        logic        got;
        logic [31:0] first_pc;

        reset           = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.inst_ready  = 1'b1;
        bus.imem_rdata  = 32'h0;
        m_pc     = 32'h0;
        m_inf    = 1'b0;
        m_inf_pc = 32'h0;
        repeat (3) cycle();
        chk("reset_valid", obs_valid, 1'b0);

        reset = 1'b0;
        req_log.delete();
        fv = -1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (obs_valid && fv < 0) fv = i;
        end
        chk("first_valid_cycle", fv, 2);
        for (int i = 0; i < 4; i++) chk("boot_addr", req_log[i], 4 * i);

        reset = 1'b1;
        cycle();
        reset = 1'b0;
        bus.inst_ready = 1'b0;
        req_log.delete();
        repeat (10) cycle();
        chk("stall_nreq", req_log.size(), 4);
        chk("stall_last_addr", req_log[3], 32'd12);
        chk("stall_head_pc", obs_pc, 32'h0);
        bus.inst_ready = 1'b1;
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (obs_valid) nv++;
        end
        chk("drain_no_bubble", nv, 4);

        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        cycle();
        bus.redirect = 1'b0;
        req_log.delete();
        got = 1'b0;
        first_pc = 32'hDEAD_BEEF;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (obs_valid && !got) begin
                got = 1'b1;
                first_pc = obs_pc;
            end
        end
        chk("redir_first_addr", req_log[0], 32'h100);
        chk("redir_first_pc", first_pc, 32'h100);

        bus.inst_ready = 1'b0;
        repeat (6) cycle();
        chk("full_count", obs_cnt, DEPTH);
        bus.inst_ready  = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        cycle();
        bus.redirect   = 1'b0;
        bus.inst_ready = 1'b0;
        cycle();
        chk("flush_valid", obs_valid, 1'b0);
        chk("flush_count", obs_cnt, 0);

        bus.inst_ready  = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        cycle();
        bus.redirect = 1'b0;
        req_log.delete();
        repeat (4) cycle();
        chk("wrap_addr0", req_log[0], 32'hFFFF_FFF8);
        chk("wrap_addr1", req_log[1], 32'hFFFF_FFFC);
        chk("wrap_addr2", req_log[2], 32'h0000_0000);

        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h300;
        cycle();
        bus.redirect = 1'b0;
        repeat (4) cycle();
        reset = 1'b1;
        cycle();
        chk("pre_reset_count", obs_cnt, 3);
        reset = 1'b0;
        req_log.delete();
        cycle();
        chk("post_reset_valid", obs_valid, 1'b0);
        chk("post_reset_addr", req_log[0], 32'h0);

        for (int i = 0; i < 400; i++) begin
            reset           = ($urandom_range(0, 99) == 0);
            bus.redirect    = ($urandom_range(0, 99) < 6);
            bus.redirect_pc = $urandom();
            bus.inst_ready  = ($urandom_range(0, 3) != 0);
            cycle();
        end
        reset        = 1'b0;
        bus.redirect = 1'b0;
        repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
